// File: rtl/platform_pio_arbiter_2x1.sv
// platform_pio_arbiter_2x1
// Shares one single-port PIO Avalon-MM slave between two Avalon-MM masters.
// The winning command is registered, presented to the PIO for exactly one
// cycle, read data is captured, and the granted master then sees a one-cycle
// waitrequest-low completion. Ties are broken round-robin and only one
// transfer is ever in flight.
//
// Ports:
//   clk, reset_n           system clock, asynchronous active-low reset
//   m0_* / m1_*            master slave ports (address, chipselect, write_n,
//                          writedata in; readdata, waitrequest out)
//   s_*                    registered command to the PIO; s_readdata is the
//                          PIO's zero-latency combinational read data
//   busy                   high whenever a transfer is in progress

module platform_pio_arbiter_2x1 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic                  m0_chipselect,
  input  logic                  m0_write_n,
  input  logic [DATA_WIDTH-1:0] m0_writedata,
  output logic [DATA_WIDTH-1:0] m0_readdata,
  output logic                  m0_waitrequest,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic                  m1_chipselect,
  input  logic                  m1_write_n,
  input  logic [DATA_WIDTH-1:0] m1_writedata,
  output logic [DATA_WIDTH-1:0] m1_readdata,
  output logic                  m1_waitrequest,
  output logic [ADDR_WIDTH-1:0] s_address,
  output logic                  s_chipselect,
  output logic                  s_write_n,
  output logic [DATA_WIDTH-1:0] s_writedata,
  input  logic [DATA_WIDTH-1:0] s_readdata,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, next_state;

  logic                  grant_q;
  logic                  last_grant;
  logic                  take_grant;
  logic                  grant_sel;
  logic [ADDR_WIDTH-1:0] cmd_address;
  logic                  cmd_write_n;
  logic [DATA_WIDTH-1:0] cmd_writedata;
  logic                  cs_q;
  logic [DATA_WIDTH-1:0] m0_rdata_q;
  logic [DATA_WIDTH-1:0] m1_rdata_q;
  logic                  m0_wait_q;
  logic                  m1_wait_q;

  // State register. Reset drops straight back to IDLE, abandoning any
  // transfer that was about to be issued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and grant decision. Requests are only looked at in IDLE, so a
  // request raised during ISSUE or DONE waits for the following IDLE cycle.
  // On a tie the master that did not win last time is chosen.
  always_comb begin
    next_state = state;
    take_grant = 1'b0;
    grant_sel  = 1'b0;
    case (state)
      IDLE: begin
        if (m0_chipselect || m1_chipselect) begin
          take_grant = 1'b1;
          next_state = ISSUE;
          if (m0_chipselect && m1_chipselect) begin
            grant_sel = ~last_grant;
          end else begin
            grant_sel = m1_chipselect;
          end
        end
      end
      ISSUE:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Command capture, PIO strobe, read-data capture and completion handshake.
  // Everything the masters and the PIO see comes from flops, so there is no
  // combinational path from a master's inputs to the PIO. The waitrequest
  // flops are loaded one cycle ahead so they are low exactly in DONE.
  // last_grant starts at 1 so master 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_q       <= 1'b0;
      last_grant    <= 1'b1;
      cmd_address   <= '0;
      cmd_write_n   <= 1'b1;
      cmd_writedata <= '0;
      cs_q          <= 1'b0;
      m0_rdata_q    <= '0;
      m1_rdata_q    <= '0;
      m0_wait_q     <= 1'b1;
      m1_wait_q     <= 1'b1;
    end else begin
      if (take_grant) begin
        grant_q <= grant_sel;
        if (grant_sel) begin
          cmd_address   <= m1_address;
          cmd_write_n   <= m1_write_n;
          cmd_writedata <= m1_writedata;
        end else begin
          cmd_address   <= m0_address;
          cmd_write_n   <= m0_write_n;
          cmd_writedata <= m0_writedata;
        end
      end

      cs_q <= (next_state == ISSUE);

      if ((state == ISSUE) && cmd_write_n) begin
        if (grant_q) begin
          m1_rdata_q <= s_readdata;
        end else begin
          m0_rdata_q <= s_readdata;
        end
      end

      m0_wait_q <= ~((next_state == DONE) && !grant_q);
      m1_wait_q <= ~((next_state == DONE) && grant_q);

      if (state == DONE) begin
        last_grant <= grant_q;
      end
    end
  end

  assign s_address      = cmd_address;
  assign s_chipselect   = cs_q;
  assign s_write_n      = cmd_write_n;
  assign s_writedata    = cmd_writedata;
  assign m0_readdata    = m0_rdata_q;
  assign m1_readdata    = m1_rdata_q;
  assign m0_waitrequest = m0_wait_q;
  assign m1_waitrequest = m1_wait_q;
  assign busy           = (state != IDLE);

endmodule
